// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_prefetch_queue: fetch PC generator, one-outstanding imem handshake |
// | and prefetch FIFO feeding IF/ID, flushed by MEM-stage redirects. Rev 1.0 |
// +--------------------------------------------------------------------------+
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd116
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        deq,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pcplus4
);

  localparam int            AW   = $clog2(DEPTH);
  localparam int            CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_lat_addr;
  logic          r_outstanding;
  logic          r_drop;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_instr_mem [DEPTH];
  logic [31:0]   r_pcp4_mem  [DEPTH];

  logic          w_accept;
  logic          w_resp;
  logic          w_push;
  logic          w_pop;
  logic          w_outstanding_nxt;
  logic          w_drop_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_req_nxt;

  always_comb begin
    w_accept          = imem_req & imem_ready;
    w_resp            = imem_rvalid & r_outstanding;
    w_push            = w_resp & ~r_drop & ~redirect;
    w_pop             = deq & (r_count != '0) & ~redirect;
    w_outstanding_nxt = w_accept | (r_outstanding & ~w_resp);
    // On redirect, whatever is still in flight afterwards must be discarded.
    w_drop_nxt        = redirect ? w_outstanding_nxt : (r_drop & ~w_resp);
    w_count_nxt       = redirect ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
    w_req_nxt         = ~w_outstanding_nxt & (w_count_nxt < FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_lat_addr    <= '0;
      r_outstanding <= 1'b0;
      r_drop        <= 1'b0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      imem_req      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr_mem[i] <= '0;
        r_pcp4_mem[i]  <= '0;
      end
    end else begin
      r_outstanding <= w_outstanding_nxt;
      r_drop        <= w_drop_nxt;
      r_count       <= w_count_nxt;
      imem_req      <= w_req_nxt;
      if (w_accept) begin
        r_lat_addr <= r_fetch_pc;
      end
      if (redirect) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_instr_mem[r_wr_ptr] <= imem_rdata;
          r_pcp4_mem[r_wr_ptr]  <= r_lat_addr + 32'd4;
          r_wr_ptr              <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
      end
    end
  end

  assign imem_addr   = r_fetch_pc;
  assign out_valid   = (r_count != '0);
  assign out_instr   = out_valid ? r_instr_mem[r_rd_ptr] : '0;
  assign out_pcplus4 = out_valid ? r_pcp4_mem[r_rd_ptr]  : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_prefetch_queue: directed bench with a latency-programmable      |
// | instruction memory responder. Rev 1.0                                    |
// +--------------------------------------------------------------------------+
module tb_fetch_prefetch_queue;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pcplus4;

  int total;
  int bad;

  // responder state
  logic        acc_seen;
  int          acc_cnt;
  int          resp_cnt;
  logic [31:0] acc_log [$];
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          lat;

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'd116)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .deq         (deq),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pcplus4 (out_pcplus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; memory answers `lat` cycles after an accepted request.
  task automatic tick();
    logic        a;
    logic [31:0] ad;
    a  = imem_req & imem_ready & rst_n;
    ad = imem_addr;
    @(posedge clk);
    @(negedge clk);
    acc_seen    = a;
    imem_rvalid = 1'b0;
    if (a) begin
      acc_cnt++;
      acc_log.push_back(ad);
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_addr = ad;
    end
    if (pend) begin
      if (pend_cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(pend_addr);
        pend        = 1'b0;
        resp_cnt++;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  task automatic clear_log();
    acc_log.delete();
    acc_cnt  = 0;
    resp_cnt = 0;
    pend     = 1'b0;
    acc_seen = 1'b0;
  endtask

  task automatic do_reset(input logic ready, input int l);
    rst_n       = 1'b0;
    imem_ready  = ready;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    deq         = 1'b0;
    lat         = l;
    clear_log();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) check({tag, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_acc(input logic [31:0] addr);
    int n;
    n = 0;
    tick();
    while (!(acc_seen && acc_log[acc_log.size()-1] == addr) && n < 40) begin
      tick();
      n++;
    end
    if (!(acc_seen && acc_log[acc_log.size()-1] == addr))
      check("wait_acc_timeout", addr, 32'hFFFF_FFFF);
  endtask

  initial begin
    int base;
    clk   = 1'b0;
    total = 0;
    bad   = 0;

    // reset values and basic fill
    do_reset(1'b1, 1);
    rst_n = 1'b0;
    #1;
    check("rst_req",   32'(imem_req),  32'd0);
    check("rst_addr",  imem_addr,      32'd116);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", out_instr,      32'd0);
    check("rst_pcp4",  out_pcplus4,    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) tick();
    check("fill_acc_cnt", 32'(acc_cnt), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("fill_addr%0d", i), acc_log[i], 32'd116 + 32'(4 * i));
    check("fill_req",   32'(imem_req),  32'd0);
    check("fill_valid", 32'(out_valid), 32'd1);
    check("fill_instr", out_instr,      word_at(32'd116));
    check("fill_pcp4",  out_pcplus4,    32'd120);

    // pop two from a full queue, refetch resumes at 132
    deq = 1'b1;
    tick();
    tick();
    deq = 1'b0;
    check("pop_acc_cnt", 32'(acc_cnt), 32'd5);
    check("pop_refetch", acc_log[4],   32'd132);
    check("pop_instr",   out_instr,    word_at(32'd124));
    check("pop_pcp4",    out_pcplus4,  32'd128);
    repeat (6) tick();
    check("pop_no_overflow", 32'(acc_cnt), 32'd6);
    check("pop_full_req",    32'(imem_req), 32'd0);

    // redirect while the 124 fetch is in flight
    do_reset(1'b1, 3);
    wait_acc(32'd124);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_020E;
    tick();
    redirect = 1'b0;
    check("redir_valid", 32'(out_valid), 32'd0);
    check("redir_req",   32'(imem_req),  32'd0);
    base = acc_cnt;
    wait_valid("redir");
    check("redir_next_addr", acc_log[base], 32'h0000_020C);
    check("redir_pcp4",      out_pcplus4,   32'h0000_0210);
    check("redir_instr",     out_instr,     word_at(32'h0000_020C));

    // redirect together with deq at count=3
    do_reset(1'b1, 1);
    begin
      int n;
      n = 0;
      while (resp_cnt < 3 && n < 40) begin
        tick();
        n++;
      end
    end
    imem_ready = 1'b0;
    tick();
    check("rd_pre_valid", 32'(out_valid), 32'd1);
    check("rd_pre_head",  out_pcplus4,    32'd120);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0400;
    deq         = 1'b1;
    tick();
    redirect = 1'b0;
    deq      = 1'b0;
    check("rd_valid", 32'(out_valid), 32'd0);
    check("rd_req",   32'(imem_req),  32'd1);
    check("rd_addr",  imem_addr,      32'h0000_0400);
    tick();
    check("rd_no_underflow", 32'(out_valid), 32'd0);
    imem_ready = 1'b1;
    base = acc_cnt;
    wait_valid("rd");
    check("rd_target", acc_log[base], 32'h0000_0400);
    check("rd_pcp4",   out_pcplus4,   32'h0000_0404);

    // memory stalls the first request for 5 cycles
    do_reset(1'b0, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_req%0d", i),  32'(imem_req), 32'd1);
      check($sformatf("stall_addr%0d", i), imem_addr,     32'd116);
      tick();
    end
    check("stall_no_acc", 32'(acc_cnt), 32'd0);
    imem_ready = 1'b1;
    tick();
    check("stall_acc",      32'(acc_seen), 32'd1);
    check("stall_acc_addr", acc_log[0],    32'd116);

    // asynchronous reset with two entries queued and one fetch in flight
    do_reset(1'b1, 3);
    wait_acc(32'd124);
    tick();
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_req",   32'(imem_req),  32'd0);
    check("ar_addr",  imem_addr,      32'd116);
    check("ar_instr", out_instr,      32'd0);
    check("ar_pcp4",  out_pcplus4,    32'd0);
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    clear_log();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    tick();
    check("ar_stray_ignored", 32'(out_valid), 32'd0);
    imem_ready = 1'b1;
    wait_valid("ar");
    check("ar_restart_addr", acc_log[0], 32'd116);
    check("ar_restart_pcp4", out_pcplus4, 32'd120);
    check("ar_restart_instr", out_instr, word_at(32'd116));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
